melody_sequencer: RTL and testbench

- Upstream tone source for the audio output path; walks a note table held in a synchronous on-chip ROM, one entry per beat.
- Generates a signed square-wave sample for the current note.
- Output sample is summed with the codec input samples before the Audio_Controller write interface.
- Provides start, stop and loop control, plus a status and address readout for HEX display.

---
 rtl/melody_sequencer.sv | 168 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Walks a note table in a synchronous ROM (one entry per beat) and produces a
//   signed square-wave sample for the current note.
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   pulse: begin/restart playback at address 0
//   stop      in   pulse: abort playback (wins over start)
//   loop      in   wrap from LAST_ADDR to 0 instead of finishing
//   mute      in   force sample to 0, sequencing continues
//   rom_addr  out  note ROM address (also shown on HEX display)
//   rom_q     in   note ROM data: [18:0] half-period, all-ones = end marker
//   sample    out  signed tone sample
//   playing   out  high in FETCH, LOAD and PLAY
//   done      out  one-cycle pulse on entry to DONE
module melody_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int NOTE_W      = 20,
    parameter int LAST_ADDR   = 140,
    parameter int BEAT_CYCLES = 9500000,
    parameter int ROM_LAT     = 2,
    parameter int AMPLITUDE   = 10000000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic                     mute,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [NOTE_W-1:0]        rom_q,
    output logic signed [31:0]       sample,
    output logic                     playing,
    output logic                     done
);

    localparam int BEAT_W = $clog2(BEAT_CYCLES + 1);
    localparam int WAIT_W = $clog2(ROM_LAT + 1);
    localparam logic signed [31:0] AMP_POS = 32'(AMPLITUDE);
    localparam logic signed [31:0] AMP_NEG = -AMP_POS;

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StDone} state_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [18:0]        phase_cnt;
    logic [18:0]        half_period;
    logic               phase;

    logic [18:0]        sq_cnt_next;
    logic               sq_phase_next;
    logic signed [31:0] tone;

    // Square generator step; half_period of 0 is a rest and holds the counter.
    always_comb begin
        sq_cnt_next   = phase_cnt;
        sq_phase_next = phase;
        if (half_period != '0) begin
            if (phase_cnt == half_period) begin
                sq_cnt_next   = '0;
                sq_phase_next = ~phase;
            end else begin
                sq_cnt_next = phase_cnt + 1'b1;
            end
        end
    end

    // Level for the current phase; registered into sample one cycle later.
    always_comb begin
        if (mute || half_period == '0) begin
            tone = '0;
        end else begin
            tone = phase ? AMP_POS : AMP_NEG;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= StIdle;
            rom_addr    <= '0;
            sample      <= '0;
            playing     <= 1'b0;
            done        <= 1'b0;
            wait_cnt    <= '0;
            beat_cnt    <= '0;
            phase_cnt   <= '0;
            half_period <= '0;
            phase       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= StIdle;
                sample  <= '0;
                playing <= 1'b0;
            end else if (start) begin
                state     <= StFetch;
                rom_addr  <= '0;
                wait_cnt  <= '0;
                beat_cnt  <= '0;
                phase_cnt <= '0;
                playing   <= 1'b1;
                sample    <= (state == StIdle || state == StDone) ? '0 : tone;
            end else begin
                case (state)
                    StIdle, StDone: begin
                        sample <= '0;
                    end
                    StFetch: begin
                        // Keep the previous note sounding while the ROM settles.
                        phase_cnt <= sq_cnt_next;
                        phase     <= sq_phase_next;
                        sample    <= tone;
                        if (wait_cnt == WAIT_W'(ROM_LAT - 1)) begin
                            wait_cnt <= '0;
                            state    <= StLoad;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    StLoad: begin
                        if (rom_q == '1) begin
                            state   <= StDone;
                            done    <= 1'b1;
                            playing <= 1'b0;
                            sample  <= '0;
                        end else begin
                            half_period <= rom_q[18:0];
                            phase_cnt   <= '0;
                            phase       <= 1'b1;
                            beat_cnt    <= '0;
                            sample      <= tone;
                            state       <= StPlay;
                        end
                    end
                    StPlay: begin
                        phase_cnt <= sq_cnt_next;
                        phase     <= sq_phase_next;
                        sample    <= tone;
                        beat_cnt  <= beat_cnt + 1'b1;
                        if (beat_cnt == BEAT_W'(BEAT_CYCLES - 1)) begin
                            beat_cnt <= '0;
                            wait_cnt <= '0;
                            if (rom_addr < ADDR_W'(LAST_ADDR)) begin
                                rom_addr <= rom_addr + 1'b1;
                                state    <= StFetch;
                            end else if (loop) begin
                                rom_addr <= '0;
                                state    <= StFetch;
                            end else begin
                                state   <= StDone;
                                done    <= 1'b1;
                                playing <= 1'b0;
                                sample  <= '0;
                            end
                        end
                    end
                    default: begin
                        state  <= StIdle;
                        sample <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a 4-entry behavioural ROM,
// BEAT_CYCLES=20, LAST_ADDR=3, ROM_LAT=2. Each note occupies 23 cycles
// (2 FETCH + 1 LOAD + 20 PLAY). k counts negedges after the start edge.
module tb_melody_sequencer;

    localparam logic signed [31:0] AMP = 32'sd10000000;

    logic               clk = 1'b0;
    logic               reset, start, stop, loop, mute;
    logic [9:0]         rom_addr;
    logic [19:0]        rom_q;
    logic signed [31:0] sample;
    logic               playing, done;

    logic [19:0] mem [0:3];
    logic [19:0] rom_r1;
    int          hp_tab [4] = '{4, 0, 9, 4};
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // Two-cycle synchronous ROM.
    always_ff @(posedge clk) begin
        rom_r1 <= mem[rom_addr[1:0]];
        rom_q  <= rom_r1;
    end

    melody_sequencer #(
        .ADDR_W(10), .NOTE_W(20), .LAST_ADDR(3), .BEAT_CYCLES(20),
        .ROM_LAT(2), .AMPLITUDE(10000000)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .mute(mute), .rom_addr(rom_addr), .rom_q(rom_q), .sample(sample),
        .playing(playing), .done(done)
    );

    // Note n's PLAY begins at edge 4+23n; its first level shows at k=5+23n and
    // the generator keeps running through the next note's FETCH/LOAD.
    function automatic logic signed [31:0] exp_tone(int k);
        int n, h;
        if (k < 5) return 32'sd0;
        n = (k - 5) / 23;
        h = hp_tab[n % 4];
        if (h == 0) return 32'sd0;
        return (((k - 5 - 23 * n) / (h + 1)) % 2 == 0) ? AMP : -AMP;
    endfunction

    function automatic logic [9:0] exp_addr(int k);
        return 10'((k - 1) / 23 % 4);
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; mute = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rom_addr !== 10'd0 || sample !== 32'sd0 || playing !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: addr=%0d sample=%0d playing=%b done=%b, want 0/0/0/0",
                     rom_addr, sample, playing, done);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (playing !== 1'b0 || sample !== 32'sd0) begin
            errors++;
            $display("FAIL idle_after_reset: playing=%b sample=%0d, want 0/0", playing, sample);
        end
    endtask

    // Test 1: first note, 5-cycle levels, step to address 1 after 23 cycles.
    task automatic test_first_note();
        loop = 1'b0; mute = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (rom_addr !== exp_addr(k) || playing !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL first_note k=%0d: addr=%0d playing=%b done=%b, want %0d/1/0",
                         k, rom_addr, playing, done, exp_addr(k));
            end
            checks++;
            if (sample !== exp_tone(k)) begin
                errors++;
                $display("FAIL first_note_sample k=%0d: got %0d want %0d", k, sample, exp_tone(k));
            end
        end
    endtask

    // Test 2: rest, 10-cycle note, last note then DONE (continues from k=24).
    task automatic test_rest_and_done();
        for (int k = 25; k <= 96; k++) begin
            @(negedge clk);
            if (k < 93) begin
                checks++;
                if (rom_addr !== exp_addr(k) || sample !== exp_tone(k) || done !== 1'b0) begin
                    errors++;
                    $display("FAIL song k=%0d: addr=%0d sample=%0d done=%b, want %0d/%0d/0",
                             k, rom_addr, sample, done, exp_addr(k), exp_tone(k));
                end
            end else begin
                checks++;
                if (done !== (k == 93) || playing !== 1'b0 || sample !== 32'sd0 ||
                    rom_addr !== 10'd3) begin
                    errors++;
                    $display("FAIL done k=%0d: done=%b playing=%b sample=%0d addr=%0d, want %b/0/0/3",
                             k, done, playing, sample, rom_addr, k == 93);
                end
            end
        end
    endtask

    // Test 3: loop wraps 3 -> 0, no done pulse.
    task automatic test_loop();
        do_reset();
        loop = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (rom_addr !== exp_addr(k) || done !== 1'b0 || playing !== 1'b1 ||
                (k >= 5 && sample !== exp_tone(k))) begin
                errors++;
                $display("FAIL loop k=%0d: addr=%0d done=%b playing=%b sample=%0d, want %0d/0/1/%0d",
                         k, rom_addr, done, playing, sample, exp_addr(k), exp_tone(k));
            end
        end
        loop = 1'b0;
    endtask

    // Test 4: end marker at address 2 enters DONE from LOAD.
    task automatic test_end_marker();
        int pulses = 0;
        mem[2] = 20'hFFFFF;
        do_reset();
        start = 1'b1;
        for (int k = 1; k <= 56; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) pulses++;
            if (k == 50) begin
                checks++;
                if (done !== 1'b1 || playing !== 1'b0 || sample !== 32'sd0 || rom_addr !== 10'd2) begin
                    errors++;
                    $display("FAIL marker_done: done=%b playing=%b sample=%0d addr=%0d, want 1/0/0/2",
                             done, playing, sample, rom_addr);
                end
            end else if (k > 50) begin
                checks++;
                if (playing !== 1'b0 || sample !== 32'sd0 || rom_addr !== 10'd2) begin
                    errors++;
                    $display("FAIL marker_hold k=%0d: playing=%b sample=%0d addr=%0d, want 0/0/2",
                             k, playing, sample, rom_addr);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL marker_pulses: got %0d want 1", pulses);
        end
        mem[2] = 20'd9;
    endtask

    // Test 5: start+stop together -> IDLE; start alone mid-note -> restart.
    task automatic test_start_stop();
        do_reset();
        start = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            checks++;
            if (playing !== 1'b0 || sample !== 32'sd0 || done !== 1'b0 || rom_addr !== 10'd2) begin
                errors++;
                $display("FAIL start_stop i=%0d: playing=%b sample=%0d done=%b addr=%0d, want 0/0/0/2",
                         i, playing, sample, done, rom_addr);
            end
        end
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (rom_addr !== exp_addr(k) || playing !== 1'b1 ||
                (k >= 5 && sample !== exp_tone(k))) begin
                errors++;
                $display("FAIL restart k=%0d: addr=%0d playing=%b sample=%0d, want %0d/1/%0d",
                         k, rom_addr, playing, sample, exp_addr(k), exp_tone(k));
            end
        end
    endtask

    // Test 6: mute silences but sequencing advances; reset mid-beat.
    task automatic test_mute_reset();
        do_reset();
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        mute = 1'b1;
        for (int k = 11; k <= 60; k++) begin
            @(negedge clk);
            checks++;
            if (sample !== 32'sd0 || rom_addr !== exp_addr(k)) begin
                errors++;
                $display("FAIL mute k=%0d: sample=%0d addr=%0d, want 0/%0d",
                         k, sample, rom_addr, exp_addr(k));
            end
        end
        mute = 1'b0;
        @(negedge clk);
        checks++;
        if (sample !== exp_tone(61)) begin
            errors++;
            $display("FAIL unmute: sample=%0d want %0d", sample, exp_tone(61));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (rom_addr !== 10'd0 || sample !== 32'sd0 || playing !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: addr=%0d sample=%0d playing=%b done=%b, want 0/0/0/0",
                     rom_addr, sample, playing, done);
        end
    endtask

    initial begin
        mem[0] = 20'd4; mem[1] = 20'd0; mem[2] = 20'd9; mem[3] = 20'd4;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; mute = 1'b0;
        test_reset();
        test_first_note();
        test_rest_and_done();
        test_loop();
        test_end_marker();
        test_start_stop();
        test_mute_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
